// File: rtl/instr_loader_mem.sv
// instr_loader_mem: boot-time instruction store. A byte-stream loader fills
// the array MSB-first and holds the CPU in reset until the image is complete.
// The CPU then fetches words combinationally from BASE_ADDR upward.
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to require a trailing
// modulo-256 checksum byte before the CPU is released.
module instr_loader_mem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        cpu_reset,
  output logic        loaded,
  output logic        load_error
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = $clog2(DEPTH_WORDS + 1);

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_ERROR, S_CHECK} state_e;
`else
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_ERROR} state_e;
`endif

  state_e         state_q, state_d;
  logic [CW-1:0]  wp_q, wp_d;
  logic [CW-1:0]  word_count_q, word_count_d;
  logic [1:0]     lane_q, lane_d;
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    merged;
  logic           wr_en;
  logic           accept;
  logic           overflow;
  logic [29:0]    word_off;
  logic [31:0]    mem_q [DEPTH_WORDS];
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  assign accept   = load_valid & load_ready;
  assign overflow = (wp_q == CW'(DEPTH_WORDS));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic: only accepted bytes move the FSM; RUN and ERROR are terminal
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (overflow)       state_d = S_ERROR;
`ifdef INSTR_LOADER_CHECKSUM_EN
          else if (load_last) state_d = S_CHECK;
`else
          else if (load_last) state_d = S_RUN;
`endif
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (load_byte == csum_q) ? S_RUN : S_ERROR;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // Output decode from state
  always_comb begin
    load_ready = 1'b0;
    cpu_reset  = 1'b1;
    loaded     = 1'b0;
    load_error = 1'b0;
    case (state_q)
      S_LOAD:  load_ready = clk_enable;
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK: load_ready = clk_enable;
`endif
      S_RUN: begin
        cpu_reset = 1'b0;
        loaded    = 1'b1;
      end
      S_ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  // Byte lane merge: incoming byte lands in the lane slot, lower lanes stay zero
  always_comb begin
    merged = 32'h0;
    case (lane_q)
      2'd0: merged = {load_byte, 24'h0};
      2'd1: merged = {acc_q[31:24], load_byte, 16'h0};
      2'd2: merged = {acc_q[31:16], load_byte, 8'h0};
      2'd3: merged = {acc_q[31:8], load_byte};
      default: ;
    endcase
  end

  // Loader datapath next-state: pointer, lane, partial word, count, checksum
  always_comb begin
    wp_d         = wp_q;
    lane_d       = lane_q;
    acc_d        = acc_q;
    word_count_d = word_count_q;
    wr_en        = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    if (state_q == S_LOAD && accept && !overflow) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_d = csum_q + load_byte;
`endif
      if (lane_q == 2'd3 || load_last) begin
        wr_en  = 1'b1;
        wp_d   = wp_q + CW'(1);
        lane_d = 2'd0;
        acc_d  = 32'h0;
      end else begin
        lane_d = lane_q + 2'd1;
        acc_d  = merged;
      end
      if (load_last) word_count_d = wp_q + CW'(1);
    end
  end

  // Loader datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q         <= '0;
      lane_q       <= 2'd0;
      acc_q        <= 32'h0;
      word_count_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q       <= 8'h0;
`endif
    end else begin
      wp_q         <= wp_d;
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      word_count_q <= word_count_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Instruction storage; contents survive reset, word_count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q[AW-1:0]] <= merged;
  end

  // Combinational fetch: NOP unless running, aligned and inside the loaded image
  assign word_off = 30'((instr_address - BASE_ADDR) >> 2);

  always_comb begin
    instr_readdata = 32'h0;
    if (state_q == S_RUN && instr_address[1:0] == 2'b00 &&
        word_off < 30'(word_count_q))
      instr_readdata = mem_q[word_off[AW-1:0]];
  end

endmodule

// File: tb/tb_instr_loader_mem.sv
// Scoreboard bench for instr_loader_mem: stimulus queues expected fetch data
// or status, a monitor pops and compares on the falling edge.
module tb_instr_loader_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst2 = 1'b1;
  logic        clk_enable = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_valid2 = 1'b0;
  logic [7:0]  load_byte = 8'h0;
  logic        load_last = 1'b0;
  logic [31:0] instr_address = 32'h0;

  logic        load_ready, cpu_reset, loaded, load_error;
  logic [31:0] instr_readdata;
  logic        load_ready2, cpu_reset2, loaded2, load_error2;
  logic [31:0] instr_readdata2;

  instr_loader_mem u_dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .cpu_reset(cpu_reset),
    .loaded(loaded), .load_error(load_error)
  );

  instr_loader_mem #(.DEPTH_WORDS(2)) u_small (
    .clk(clk), .reset(rst2), .clk_enable(clk_enable),
    .load_valid(load_valid2), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready2), .instr_address(instr_address),
    .instr_readdata(instr_readdata2), .cpu_reset(cpu_reset2),
    .loaded(loaded2), .load_error(load_error2)
  );

  always #5 clk = ~clk;

  // kind: 0 fetch main, 1 status main, 2 fetch small, 3 status small
  typedef struct {
    int          kind;
    int          tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] act;
  logic        chk_strobe = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;
  int          tag_cnt = 0;
  logic [7:0]  sum0 = 8'h0;

  // Monitor: one scoreboard entry per strobe
  always @(negedge clk) begin
    if (chk_strobe) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_empty: strobe with no expected entry at %0t", $time);
      end else begin
        cur = sb.pop_front();
        case (cur.kind)
          0:       act = instr_readdata;
          1:       act = {28'h0, cpu_reset, loaded, load_error, load_ready};
          2:       act = instr_readdata2;
          default: act = {28'h0, cpu_reset2, loaded2, load_error2, load_ready2};
        endcase
        if (act !== cur.exp)
          $display("FAIL chk%0d kind%0d addr=%08h: got %08h expected %08h",
                   cur.tag, cur.kind, instr_address, act, cur.exp);
        else
          n_pass++;
      end
    end
  end

  task automatic chk(input int kind, input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.tag  = tag_cnt;
    e.exp  = exp;
    tag_cnt++;
    instr_address = addr;
    sb.push_back(e);
    chk_strobe = 1'b1;
    @(negedge clk);
    #1;
    chk_strobe = 1'b0;
  endtask

  // Status nibble: {cpu_reset, loaded, load_error, load_ready}
  task automatic st(input int which, input logic [3:0] s);
    chk(which == 0 ? 1 : 3, 32'h0, {28'h0, s});
  endtask

  task automatic send(input logic [7:0] b, input logic last, input int which);
    load_byte = b;
    load_last = last;
    if (which == 0) begin
      load_valid = 1'b1;
      sum0 = sum0 + b;
    end else begin
      load_valid2 = 1'b1;
    end
    @(posedge clk);
    #1;
    load_valid  = 1'b0;
    load_valid2 = 1'b0;
    load_last   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    sum0  = 8'h0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // With the checksum feature the image only runs after its checksum byte
  task automatic end_load();
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(sum0, 1'b0, 0);
`endif
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    for (int i = 0; i < bytes.size(); i++)
      send(bytes[i], (i == bytes.size() - 1), 0);
    end_load();
  endtask

  initial begin
    #2;
    reset = 1'b0;
    rst2  = 1'b0;
    #1;
    // Reset state, with reset still held
    st(0, 4'b1001);
    chk(0, 32'hBFC00000, 32'h0);
    reset = 1'b1;
    rst2  = 1'b1;

    // Four-word program, then RUN
    send(8'h24, 1'b0, 0); send(8'h84, 1'b0, 0); send(8'h00, 1'b0, 0); send(8'h03, 1'b0, 0);
    chk(0, 32'hBFC00000, 32'h0);
    st(0, 4'b1001);
    send(8'h38, 1'b0, 0); send(8'h82, 1'b0, 0); send(8'h00, 1'b0, 0); send(8'h06, 1'b0, 0);
    send(8'h00, 1'b0, 0); send(8'h00, 1'b0, 0); send(8'h00, 1'b0, 0); send(8'h08, 1'b0, 0);
    send(8'h24, 1'b0, 0); send(8'h00, 1'b0, 0); send(8'h00, 1'b0, 0); send(8'h00, 1'b1, 0);
    end_load();
    st(0, 4'b0100);
    chk(0, 32'hBFC00004, 32'h38820006);
    chk(0, 32'hBFC0000C, 32'h24000000);
    chk(0, 32'hBFC00010, 32'h00000000);
    chk(0, 32'hBFC00000, 32'h24840003);
    chk(0, 32'hBFC00008, 32'h00000008);
    // RUN is terminal: further bytes are ignored
    send(8'hFF, 1'b1, 0);
    st(0, 4'b0100);
    chk(0, 32'hBFC00000, 32'h24840003);

    // Partial last word, zero-padded; stale word 2 must be hidden
    do_reset();
    st(0, 4'b1001);
    send_list('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    chk(0, 32'hBFC00004, 32'h55660000);
    chk(0, 32'hBFC00002, 32'h00000000);
    chk(0, 32'h00000000, 32'h00000000);
    chk(0, 32'hBFC00000, 32'h11223344);
    chk(0, 32'hBFC00008, 32'h00000000);

    // Reset mid-load discards the partial image
    do_reset();
    send(8'h01, 1'b0, 0); send(8'h02, 1'b0, 0); send(8'h03, 1'b0, 0);
    do_reset();
    send_list('{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    chk(0, 32'hBFC00000, 32'hAABBCCDD);
    chk(0, 32'hBFC00004, 32'h00000000);

    // clk_enable low freezes the loader even with a byte offered
    do_reset();
    send(8'h11, 1'b0, 0); send(8'h22, 1'b0, 0);
    load_byte  = 8'h99;
    load_valid = 1'b1;
    clk_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    st(0, 4'b1000);
    repeat (3) @(posedge clk);
    #1;
    load_valid = 1'b0;
    clk_enable = 1'b1;
    send_list('{8'h33, 8'h44, 8'h55, 8'h66, 8'h77});
    st(0, 4'b0100);
    chk(0, 32'hBFC00000, 32'h11223344);
    chk(0, 32'hBFC00004, 32'h55667700);

    // Single last byte with nothing before it
    do_reset();
    send_list('{8'hAB});
    chk(0, 32'hBFC00000, 32'hAB000000);
    chk(0, 32'hBFC00004, 32'h00000000);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Good and bad checksum trailers
    do_reset();
    send(8'h01, 1'b0, 0); send(8'h02, 1'b0, 0); send(8'h03, 1'b0, 0); send(8'h04, 1'b1, 0);
    st(0, 4'b1001);
    send(8'h0A, 1'b1, 0);
    st(0, 4'b0100);
    chk(0, 32'hBFC00000, 32'h01020304);
    do_reset();
    send(8'h01, 1'b0, 0); send(8'h02, 1'b0, 0); send(8'h03, 1'b0, 0); send(8'h04, 1'b1, 0);
    send(8'h0B, 1'b0, 0);
    st(0, 4'b1010);
    chk(0, 32'hBFC00000, 32'h00000000);
`endif

    // Overflow on a two-word store
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0, 1);
    st(1, 4'b1001);
    send(8'h09, 1'b0, 1);
    st(1, 4'b1010);
    chk(2, 32'hBFC00000, 32'h00000000);
    chk(2, 32'hBFC00004, 32'h00000000);
    send(8'h0A, 1'b1, 1);
    st(1, 4'b1010);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
